// File: rtl/mmio_pkg.sv
// Shared MMIO address map, direction codes, debounce state encoding and reset position.
package mmio_pkg;

    localparam logic [16:0] AddrDmemLimit = 17'd4096;
    localparam logic [16:0] AddrDir       = 17'd4100;
    localparam logic [16:0] AddrPosX      = 17'd4200;
    localparam logic [16:0] AddrPosY      = 17'd4201;
    localparam logic [16:0] AddrFrame     = 17'd4202;

    localparam logic [2:0] DirNone  = 3'd0;
    localparam logic [2:0] DirUp    = 3'd1;
    localparam logic [2:0] DirRight = 3'd2;
    localparam logic [2:0] DirDown  = 3'd3;
    localparam logic [2:0] DirLeft  = 3'd4;

    localparam logic [31:0] ResetPos = 32'd240;

    typedef enum logic [1:0] {
        StIdle,
        StCount,
        StAccept
    } db_state_e;

    // Button pattern bit order is {left, down, right, up}; chords and no-press map to none.
    function automatic logic [2:0] dir_map(input logic [3:0] buttons);
        logic [2:0] code;
        case (buttons)
            4'b0001: code = DirUp;
            4'b0010: code = DirRight;
            4'b0100: code = DirDown;
            4'b1000: code = DirLeft;
            default: code = DirNone;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/mmio_if.sv
// Processor-side MMIO/DMEM bus: address, store data and enable in, gated enable and read data out.
interface mmio_if;

    logic [16:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic        dmem_wren;
    logic [31:0] proc_data_in;

    modport master (
        output address_dmem,
        output data,
        output wren,
        input  dmem_wren,
        input  proc_data_in
    );

    modport slave (
        input  address_dmem,
        input  data,
        input  wren,
        output dmem_wren,
        output proc_data_in
    );

endinterface

// File: rtl/dir_debounce.sv
// Debounces the 4-bit direction pattern and publishes a direction code once it has been stable.
module dir_debounce
    import mmio_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] buttons,
    output logic [2:0] dir_code
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    db_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      pat_q, pat_d;
    logic [2:0]      code_q, code_d;
    logic            changed;

    assign changed = (buttons != pat_q);

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            pat_q   <= '0;
            code_q  <= DirNone;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        code_d  = code_q;
        unique case (state_q)
            StIdle: begin
                if (changed) begin
                    state_d = StCount;
                    cnt_d   = '0;
                    pat_d   = buttons;
                end
            end
            StCount: begin
                if (changed) begin
                    cnt_d = '0;
                    pat_d = buttons;
                end else if (cnt_q == CntLast) begin
                    state_d = StAccept;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StAccept: begin
                code_d  = dir_map(pat_q);
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign dir_code = code_q;

endmodule

// File: rtl/mmio_ctrl.sv
// MMIO controller: DMEM write gating, clamped position registers, frame snapshot and readback.
module mmio_ctrl
    import mmio_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned X_MAX           = 639,
    parameter int unsigned Y_MAX           = 479
) (
    input  logic        clock,
    input  logic        reset,
    mmio_if.slave       bus,
    input  logic        upSig,
    input  logic        rightSig,
    input  logic        downSig,
    input  logic        leftSig,
    input  logic        vsync,
    output logic [31:0] player0_x,
    output logic [31:0] player0_y,
    output logic [31:0] frame_count
);

    function automatic logic [31:0] clamp(input logic [31:0] value, input logic [31:0] limit);
        if (value[31]) return '0;
        if (value > limit) return limit;
        return value;
    endfunction

    logic [2:0]  dir_code;
    logic [31:0] pos_x_q, pos_y_q, snap_x_q, snap_y_q, frame_q;
    logic [31:0] rdata_q, rdata_d;
    logic [2:0]  vsync_q;
    logic        frame_start;

    dir_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_dir_debounce (
        .clock   (clock),
        .reset   (reset),
        .buttons ({leftSig, downSig, rightSig, upSig}),
        .dir_code(dir_code)
    );

    assign bus.dmem_wren = bus.wren && (bus.address_dmem < AddrDmemLimit);

    // vsync_q[1:0] is the synchronizer; vsync_q[2] is the previous synchronized level.
    assign frame_start = vsync_q[1] & ~vsync_q[2];

    always_comb begin
        rdata_d = rdata_q;
        if (!bus.wren) begin
            case (bus.address_dmem)
                AddrDir:   rdata_d = {29'b0, dir_code};
                AddrPosX:  rdata_d = pos_x_q;
                AddrPosY:  rdata_d = pos_y_q;
                AddrFrame: rdata_d = frame_q;
                default:   rdata_d = rdata_q;
            endcase
        end
    end

    // Snapshot reads the pre-edge positions, so a coincident store lands in the next frame.
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            pos_x_q  <= ResetPos;
            pos_y_q  <= ResetPos;
            snap_x_q <= ResetPos;
            snap_y_q <= ResetPos;
            frame_q  <= '0;
            rdata_q  <= '0;
            vsync_q  <= '0;
        end else begin
            vsync_q <= {vsync_q[1:0], vsync};
            rdata_q <= rdata_d;
            if (frame_start) begin
                snap_x_q <= pos_x_q;
                snap_y_q <= pos_y_q;
                frame_q  <= frame_q + 32'd1;
            end
            if (bus.wren && bus.address_dmem == AddrPosX) pos_x_q <= clamp(bus.data, 32'(X_MAX));
            if (bus.wren && bus.address_dmem == AddrPosY) pos_y_q <= clamp(bus.data, 32'(Y_MAX));
        end
    end

    assign bus.proc_data_in = rdata_q;
    assign player0_x        = snap_x_q;
    assign player0_y        = snap_y_q;
    assign frame_count      = frame_q;

endmodule

// File: tb/tb_mmio_ctrl.sv
// Randomized self-checking bench for mmio_ctrl against a timestamp-based behavioural model.
module tb_mmio_ctrl;

    localparam int unsigned D    = 4;
    localparam int unsigned XMAX = 639;
    localparam int unsigned YMAX = 479;

    logic clock = 1'b0;
    logic reset;
    logic upSig, rightSig, downSig, leftSig, vsync;
    logic [31:0] player0_x, player0_y, frame_count;

    mmio_if bus ();

    mmio_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .X_MAX          (XMAX),
        .Y_MAX          (YMAX)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .upSig      (upSig),
        .rightSig   (rightSig),
        .downSig    (downSig),
        .leftSig    (leftSig),
        .vsync      (vsync),
        .player0_x  (player0_x),
        .player0_y  (player0_y),
        .frame_count(frame_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Model state
    logic [31:0] m_pos_x, m_pos_y, m_snap_x, m_snap_y, m_frame, m_rdata, m_code;
    logic [2:0]  m_vhist;  // [0] = last sample, [1] = two edges ago, [2] = three edges ago
    logic [3:0]  m_ref;
    bit          m_track;
    int          m_edge, m_start, m_load_at;

    logic [3:0]  cur_btn = 4'b0;
    logic        cur_vs  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_code(input logic [3:0] p);
        if ($countones(p) != 1) return 32'd0;
        for (int i = 0; i < 4; i++) if (p[i]) return 32'(i + 1);
        return 32'd0;
    endfunction

    function automatic logic [31:0] exp_clamp(input logic [31:0] v, input logic [31:0] lim);
        if (v >= 32'h8000_0000) return 32'd0;
        return (v > lim) ? lim : v;
    endfunction

    task automatic model_reset();
        m_pos_x = 240; m_pos_y = 240; m_snap_x = 240; m_snap_y = 240;
        m_frame = 0; m_rdata = 0; m_code = 0; m_vhist = '0;
        m_ref = '0; m_track = 0; m_edge = 0; m_start = 0; m_load_at = -1;
    endtask

    // Advance the model by one falling edge using the inputs currently driven.
    task automatic model_edge();
        logic [3:0] s;
        bit rise;
        s    = {leftSig, downSig, rightSig, upSig};
        rise = m_vhist[1] && !m_vhist[2];
        if (!bus.wren) begin
            case (bus.address_dmem)
                17'd4100: m_rdata = m_code;
                17'd4200: m_rdata = m_pos_x;
                17'd4201: m_rdata = m_pos_y;
                17'd4202: m_rdata = m_frame;
                default: ;
            endcase
        end
        if (rise) begin
            m_snap_x = m_pos_x;
            m_snap_y = m_pos_y;
            m_frame  = m_frame + 32'd1;
        end
        if (bus.wren && bus.address_dmem == 17'd4200) m_pos_x = exp_clamp(bus.data, XMAX);
        if (bus.wren && bus.address_dmem == 17'd4201) m_pos_y = exp_clamp(bus.data, YMAX);
        m_vhist = {m_vhist[1:0], vsync};
        // Pattern accepted after D further unchanged edges; code appears one edge later.
        m_edge++;
        if (m_load_at == m_edge) begin
            m_code    = exp_code(m_ref);
            m_load_at = -1;
        end else if (s != m_ref) begin
            m_track = 1;
            m_ref   = s;
            m_start = m_edge;
        end else if (m_track && (m_edge - m_start) == int'(D)) begin
            m_track   = 0;
            m_load_at = m_edge + 1;
        end
    endtask

    task automatic check_outputs();
        logic exp_wren;
        exp_wren = bus.wren && (bus.address_dmem < 17'd4096);
        chk("dmem_wren", 32'(bus.dmem_wren), 32'(exp_wren));
        chk("proc_data_in", bus.proc_data_in, m_rdata);
        chk("player0_x", player0_x, m_snap_x);
        chk("player0_y", player0_y, m_snap_y);
        chk("frame_count", frame_count, m_frame);
    endtask

    task automatic cycle(input logic [16:0] a, input logic [31:0] d, input logic w);
        @(posedge clock);
        check_outputs();
        bus.address_dmem = a;
        bus.data         = d;
        bus.wren         = w;
        {leftSig, downSig, rightSig, upSig} = cur_btn;
        vsync = cur_vs;
        model_edge();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(17'd5000, 32'd0, 1'b0);
    endtask

    task automatic read_expect(input logic [16:0] a, input logic [31:0] exp, input string name);
        cycle(a, 32'd0, 1'b0);
        @(negedge clock);
        #1;
        chk(name, bus.proc_data_in, exp);
    endtask

    task automatic do_reset();
        @(posedge clock);
        reset = 1'b1;
        model_reset();
        #1;
        chk("reset player0_x", player0_x, 32'd240);
        chk("reset player0_y", player0_y, 32'd240);
        chk("reset frame_count", frame_count, 32'd0);
        chk("reset proc_data_in", bus.proc_data_in, 32'd0);
        repeat (2) @(posedge clock);
        reset = 1'b0;
        model_edge();
    endtask

    initial begin
        int hold_left;
        int vs_left;
        logic [16:0] a;
        logic [31:0] d;

        reset = 1'b0;
        bus.address_dmem = 17'd5000; bus.data = '0; bus.wren = 1'b0;
        {leftSig, downSig, rightSig, upSig} = 4'b0;
        vsync = 1'b0;
        model_reset();
        #1 reset = 1'b1;

        do_reset();
        read_expect(17'd4200, 32'd240, "reset read pos_x");
        read_expect(17'd4201, 32'd240, "reset read pos_y");
        read_expect(17'd4100, 32'd0, "reset read dir");

        // Store coincident with the synchronized vsync rise
        idle(3);
        cur_vs = 1'b1;
        idle(2);
        cycle(17'd4200, 32'd300, 1'b1);
        idle(2);
        chk("snapshot pre-store x", player0_x, 32'd240);
        chk("first frame_count", frame_count, 32'd1);
        cur_vs = 1'b0;
        idle(4);
        cur_vs = 1'b1;
        idle(5);
        chk("snapshot post-store x", player0_x, 32'd300);
        chk("second frame_count", frame_count, 32'd2);
        read_expect(17'd4202, 32'd2, "read frame_count");

        // Direction debounce
        cur_btn = 4'b0010;
        idle(10);
        read_expect(17'd4100, 32'd2, "right held");
        cycle(17'd4100, 32'd123, 1'b1);
        read_expect(17'd4100, 32'd2, "store to dir ignored");
        cur_btn = 4'b0000;
        idle(10);
        read_expect(17'd4100, 32'd0, "release");
        cur_btn = 4'b0001;
        idle(2);
        cur_btn = 4'b0000;
        idle(10);
        read_expect(17'd4100, 32'd0, "short up pulse");
        cur_btn = 4'b0100;
        idle(10);
        read_expect(17'd4100, 32'd3, "down held");
        cur_btn = 4'b1001;
        idle(10);
        read_expect(17'd4100, 32'd0, "up+left chord");

        // Clamping
        cycle(17'd4200, 32'd700, 1'b1);
        read_expect(17'd4200, 32'd639, "clamp x high");
        cycle(17'd4201, 32'hFFFF_FFF0, 1'b1);
        read_expect(17'd4201, 32'd0, "clamp y negative");
        cycle(17'd4201, 32'd479, 1'b1);
        read_expect(17'd4201, 32'd479, "y at limit");

        // DMEM write gating
        cycle(17'd4095, 32'd7, 1'b1);
        #1 chk("dmem_wren 4095", 32'(bus.dmem_wren), 32'd1);
        cycle(17'd4200, 32'd5, 1'b1);
        #1 chk("dmem_wren 4200", 32'(bus.dmem_wren), 32'd0);

        // Reset mid-debounce, button held through it
        cur_btn = 4'b1000;
        idle(3);
        do_reset();
        read_expect(17'd4100, 32'd0, "dir after mid-debounce reset");
        idle(D - 1);
        read_expect(17'd4100, 32'd0, "no early accept after reset");
        idle(6);
        read_expect(17'd4100, 32'd4, "left after full debounce");

        // Randomized traffic
        hold_left = 0;
        vs_left   = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            if (hold_left == 0) begin
                case ($urandom_range(0, 9))
                    0, 1:    cur_btn = 4'b0000;
                    2, 3, 4: cur_btn = 4'(4'b0001 << $urandom_range(0, 3));
                    default: cur_btn = 4'($urandom_range(0, 15));
                endcase
                hold_left = $urandom_range(1, 10);
            end
            hold_left--;
            if (vs_left == 0) begin
                cur_vs  = ~cur_vs;
                vs_left = $urandom_range(1, 15);
            end
            vs_left--;
            case ($urandom_range(0, 7))
                0:       a = 17'd4100;
                1, 6:    a = 17'd4200;
                2, 7:    a = 17'd4201;
                3:       a = 17'd4202;
                4:       a = 17'($urandom_range(0, 4095));
                default: a = 17'($urandom_range(4096, 131071));
            endcase
            case ($urandom_range(0, 3))
                0:       d = $urandom;
                1:       d = $urandom_range(0, 700);
                2:       d = $urandom_range(0, 500);
                default: d = 32'h8000_0000 | $urandom;
            endcase
            cycle(a, d, 1'($urandom_range(0, 1)));
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmio_ctrl.md
MMIO_CTRL -- requirements
Module: mmio_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: cycles a button pattern must be stable before acceptance.
REQ-002 Parameters X_MAX, default 639, and Y_MAX, default 479: inclusive clamp limits for position writes.
REQ-003 clock  in  1  master clock; all state updates on the falling edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 address_dmem  in  17  processor data address.
REQ-006 data  in  32  processor store data.
REQ-007 wren  in  1  processor store enable.
REQ-008 upSig, rightSig, downSig, leftSig  in  1 each  raw direction buttons.
REQ-009 vsync  in  1  asynchronous display frame strobe.
REQ-010 dmem_wren  out  1  gated DMEM write enable.
REQ-011 proc_data_in  out  32  registered MMIO read data.
REQ-012 player0_x, player0_y  out  32 each  frame-stable position snapshot for the display.
REQ-013 frame_count  out  32  completed-frame counter.

Function
REQ-014 dmem_wren SHALL be combinational: wren AND (address_dmem < 4096).
REQ-015 Address map: 4100 = direction (read-only), 4200 = pos_x, 4201 = pos_y, 4202 = frame_count (read-only).
REQ-016 On a falling edge with wren=0 at a mapped address, proc_data_in SHALL load that register; at any other address it SHALL hold. Latency is one falling edge.
REQ-017 Direction read SHALL return {29'b0, dir_code}; codes: 0 none/invalid, 1 up, 2 right, 3 down, 4 left.
REQ-018 Debounce FSM states: IDLE, COUNT, ACCEPT.
- IDLE -> COUNT on any change of the 4-bit button pattern; counter cleared.
- COUNT: stays while the pattern is unchanged; returns to COUNT with the counter cleared on any change; -> ACCEPT when the counter reaches DEBOUNCE_CYCLES-1.
- ACCEPT: loads dir_code, then -> IDLE.
REQ-019 An accepted pattern with exactly one button set SHALL map to its code; zero buttons or more than one button SHALL map to 0.
REQ-020 A store with wren=1 to 4200 or 4201 SHALL write pos_x or pos_y, clamped. Bit 31 set clamps to 0. A value above X_MAX or Y_MAX clamps to that limit.
REQ-021 Stores to 4100 and 4202 SHALL be ignored.
REQ-022 vsync SHALL pass through a two-flop synchronizer. A detected rising edge SHALL, on one falling edge:
- copy pos_x and pos_y into player0_x and player0_y;
- increment frame_count (wraps at 2^32-1 -> 0).
REQ-023 If a store and a snapshot occur on the same edge, the snapshot SHALL capture the pre-store value; the store is visible at the next snapshot.
REQ-024 A read of 4200 or 4201 SHALL return live pos_x or pos_y, not the snapshot.

Reset
REQ-025 On reset assertion, regardless of clock:
- pos_x, pos_y, player0_x, player0_y = 240;
- proc_data_in, frame_count, dir_code = 0;
- FSM = IDLE, debounce counter = 0, synchronizer flops = 0.
REQ-026 Reset mid-debounce SHALL discard the pending pattern, and the first post-reset pattern SHALL require the full DEBOUNCE_CYCLES.

Structure
REQ-027 The following SHALL reside in shared package mmio_pkg:
- MMIO address constants 4096, 4100, 4200, 4201, 4202;
- direction code constants;
- debounce FSM state enum;
- reset position 240.
REQ-028 Debounce FSM and code mapping SHALL be sub-module dir_debounce. Decode, clamp, snapshot and readback stay in mmio_ctrl.

Verification
REQ-029 Reset, then read 4200 and 4201 -> proc_data_in 240 and 240. Read 4100 -> 0.
REQ-030 Hold rightSig for 4 falling edges plus FSM overhead, then read 4100 -> 2.
REQ-031 Pulse upSig for 2 cycles -> code stays 0.
REQ-032 Press up+left together, then stable -> 0.
REQ-033 Store 700 to 4200 -> read 639. Store 0xFFFFFFF0 to 4201 -> read 0. Store 123 to 4100 -> direction unchanged.
REQ-034 Store 300 to 4200 on the same edge as a synchronized vsync rise:
- player0_x stays 240 and frame_count = 1;
- on the next vsync, player0_x = 300 and frame_count = 2.
REQ-035 wren=1 at address 4095 -> dmem_wren=1. wren=1 at address 4200 -> dmem_wren=0.
